// File: rtl/button_event_gen.sv
// button_event_gen: per-channel press/release/long-press/held events from debounced button levels.
// Optional auto-repeat in HELD is enabled by defining BUTTON_EVENT_AUTO_REPEAT_EN.
module button_event_gen #(
  parameter int width             = 1,
  parameter int long_press_cycles = 62_500_000,
  parameter int repeat_cycles     = 12_500_000,
  parameter int hold_cnt_width    = $clog2(long_press_cycles) + 1,
  parameter int rep_cnt_width     = $clog2(repeat_cycles) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] debounced_signal,
  output logic [width-1:0] press_pulse,
  output logic [width-1:0] release_pulse,
  output logic [width-1:0] long_press,
  output logic [width-1:0] held,
  output logic [width-1:0] repeat_pulse
);
  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;
  localparam logic [hold_cnt_width-1:0] hold_max = hold_cnt_width'(long_press_cycles);
  logic [width-1:0] level_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) level_q <= '0;
    else level_q <= debounced_signal;
  for (genvar i = 0; i < width; i++) begin : g_ch
    state_t state;
    logic [hold_cnt_width-1:0] hold_cnt;
    logic rise, fall, press_q, release_q, long_q, held_q;
    assign rise = debounced_signal[i] & ~level_q[i];
    assign fall = ~debounced_signal[i] & level_q[i];
    // A fall on the threshold edge is checked first, so release beats long-press.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        state     <= IDLE;
        hold_cnt  <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        held_q    <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        case (state)
          IDLE: if (rise) begin
            state    <= PRESSED;
            hold_cnt <= hold_cnt_width'(1);
            press_q  <= 1'b1;
          end
          PRESSED: if (fall) begin
            state     <= IDLE;
            release_q <= 1'b1;
          end else if (hold_cnt >= hold_max) begin
            state  <= HELD;
            long_q <= 1'b1;
            held_q <= 1'b1;
          end else hold_cnt <= hold_cnt + 1'b1;
          HELD: if (fall) begin
            state     <= IDLE;
            release_q <= 1'b1;
            held_q    <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
    assign long_press[i]    = long_q;
    assign held[i]          = held_q;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
    localparam logic [rep_cnt_width-1:0] rep_max = rep_cnt_width'(repeat_cycles - 1);
    logic [rep_cnt_width-1:0] rep_cnt;
    logic rep_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        rep_cnt <= '0;
        rep_q   <= 1'b0;
      end else begin
        rep_q <= 1'b0;
        if (state != HELD) rep_cnt <= '0;
        else if (!fall) begin
          rep_cnt <= (rep_cnt >= rep_max) ? '0 : rep_cnt + 1'b1;
          rep_q   <= rep_cnt >= rep_max;
        end
      end
    assign repeat_pulse[i] = rep_q;
`else
    assign repeat_pulse[i] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_button_event_gen.sv
// tb_button_event_gen: directed scenarios plus random button activity against a time-offset reference model.
module tb_button_event_gen;
  localparam int W = 4, L = 8, R = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] press_pulse, release_pulse, long_press, held, repeat_pulse;
  int checks = 0, errors = 0;
  logic [W-1:0] prev, active, e_press, e_rel, e_long, e_held, e_rep;
  int t[W];
  always #5 clk = ~clk;
  button_event_gen #(.width(W), .long_press_cycles(L), .repeat_cycles(R)) dut (
    .clk(clk), .rst_n(rst_n), .debounced_signal(din), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .long_press(long_press), .held(held), .repeat_pulse(repeat_pulse)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    prev = '0; active = '0; e_press = '0; e_rel = '0; e_long = '0; e_held = '0; e_rep = '0;
    for (int c = 0; c < W; c++) t[c] = 0;
  endtask
  // t[c] is the offset of the upcoming cycle from the press-pulse cycle P.
  task automatic model_step(input logic [W-1:0] in);
    e_press = '0; e_rel = '0; e_long = '0; e_held = '0; e_rep = '0;
    for (int c = 0; c < W; c++) begin
      if (active[c]) begin
        t[c]++;
        if (!in[c]) begin
          active[c] = 1'b0;
          e_rel[c] = 1'b1;
        end else begin
          e_long[c] = (t[c] == L);
          e_held[c] = (t[c] >= L);
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
          e_rep[c] = (t[c] > L) && ((t[c] - L) % R == 0);
`endif
        end
      end else if (in[c] && !prev[c]) begin
        active[c] = 1'b1;
        t[c] = 0;
        e_press[c] = 1'b1;
      end
    end
    prev = in;
  endtask
  task automatic compare(input string tag);
    check({tag, ".press"}, press_pulse, e_press);
    check({tag, ".release"}, release_pulse, e_rel);
    check({tag, ".long"}, long_press, e_long);
    check({tag, ".held"}, held, e_held);
    check({tag, ".repeat"}, repeat_pulse, e_rep);
  endtask
  task automatic step(input string tag);
    @(posedge clk);
    model_step(din);
    #1;
    compare(tag);
  endtask
  task automatic run(input logic [W-1:0] v, input int n, input string tag);
    din = v;
    repeat (n) step(tag);
  endtask
  initial begin
    logic [W-1:0] v;
    int rem[W];
    model_reset();
    #12;
    compare("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(4'b0000, 2, "idle");
    run(4'b0001, 3, "tap");
    run(4'b0000, 5, "tap_rel");
    run(4'b0001, 20, "long");
    run(4'b0000, 4, "long_rel");
    run(4'b0010, 8, "bound");
    run(4'b0000, 4, "bound_rel");
    run(4'b0010, 9, "bound_plus1");
    run(4'b0000, 3, "bound_plus1_rel");
    run(4'b1001, 2, "parallel");
    run(4'b0000, 3, "parallel_rel");
    run(4'b0001, 1, "glitch");
    run(4'b0000, 3, "glitch_rel");
    run(4'b0100, 12, "pre_rst");
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    compare("rst_mid_held");
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_press");
    run(4'b0100, 3, "rst_hold");
    run(4'b0000, 3, "rst_rel");
    run(4'b0001, 30, "hold30");
    run(4'b0000, 3, "hold30_rel");
    v = '0;
    for (int c = 0; c < W; c++) rem[c] = $urandom_range(1, 6);
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < W; c++) begin
        if (rem[c] == 0) begin
          v[c] = ~v[c];
          rem[c] = v[c] ? $urandom_range(1, 20) : $urandom_range(1, 6);
        end
        rem[c]--;
      end
      din = v;
      step("rand");
    end
    run(4'b0000, 3, "final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
